// File: rtl/wave_pkg.sv
// Shared constants for the orthogonal signal generator waveform ROMs.
// Holds segment geometry, midscale code and the quarter-wave sine table.
package wave_pkg;

  localparam int SEG_LEN = 100;
  localparam int NUM_SEG = 40;
  localparam int QTR_LEN = 25;
  localparam logic [11:0] MIDSCALE = 12'd2048;
  localparam int AMP = 2047;

  // round(AMP * sin(2*pi*i/SEG_LEN)) for i = 0..QTR_LEN
  localparam logic [10:0] Q [0:25] = '{
    11'd0,    11'd129,  11'd257,  11'd384,  11'd509,  11'd633,
    11'd754,  11'd872,  11'd986,  11'd1097, 11'd1203, 11'd1305,
    11'd1401, 11'd1492, 11'd1577, 11'd1656, 11'd1728, 11'd1794,
    11'd1852, 11'd1903, 11'd1947, 11'd1983, 11'd2011, 11'd2031,
    11'd2043, 11'd2047
  };

endpackage

// File: rtl/quarter_sine_lut.sv
// Maps a phase 0..99 onto an offset-binary sine code using quarter-wave symmetry.
// Purely combinational, no latency, no flow control.
module quarter_sine_lut
  import wave_pkg::*;
(
  input  logic [6:0]  phase,
  output logic [11:0] code
);

  logic [4:0]  idx;
  logic        neg;
  logic [10:0] mag;

  always_comb begin
    idx  = '0;
    neg  = 1'b0;
    if (phase <= 7'd25) begin
      idx = 5'(phase);
    end else if (phase <= 7'd50) begin
      idx = 5'(7'd50 - phase);
    end else if (phase <= 7'd75) begin
      idx = 5'(phase - 7'd50);
      neg = 1'b1;
    end else if (phase <= 7'd99) begin
      idx = 5'(7'd100 - phase);
      neg = 1'b1;
    end
    mag  = Q[idx];
    code = neg ? (MIDSCALE - {1'b0, mag}) : (MIDSCALE + {1'b0, mag});
  end

endmodule

// File: rtl/left_rom_ip.sv
// Waveform ROM: 12-bit address -> DAC code, segment k holds k+1 periods; 1-cycle latency.
// Accepts a new address every clock, no backpressure; out-of-range addresses give midscale.
module left_rom_ip
  import wave_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 12,
  parameter int PHASE_OFS = 25
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] q
);

  logic [5:0]        seg_k;
  logic [6:0]        smp_n;
  logic [12:0]       prod;
  logic [12:0]       ph_sum;
  logic [5:0]        wrap_m;
  logic [6:0]        phase_p;
  logic              in_range;
  logic [11:0]       lut_code;
  logic [DATA_W-1:0] q_d;
  logic [DATA_W-1:0] q_q;

  // Division by the segment length is unrolled into constant compares so no divider is built.
  always_comb begin
    seg_k = '0;
    for (int i = 1; i <= NUM_SEG; i++) begin
      if (int'(address) >= i * SEG_LEN) seg_k = 6'(i);
    end
    smp_n    = 7'(int'(address) - int'(seg_k) * SEG_LEN);
    in_range = (int'(address) < NUM_SEG * SEG_LEN);
    prod     = 13'((int'(seg_k) + 1) * int'(smp_n));
    ph_sum   = prod + 13'(PHASE_OFS);
    wrap_m   = '0;
    for (int i = 1; i <= NUM_SEG + 1; i++) begin
      if (int'(ph_sum) >= i * SEG_LEN) wrap_m = 6'(i);
    end
    phase_p  = 7'(int'(ph_sum) - int'(wrap_m) * SEG_LEN);
  end

  quarter_sine_lut u_lut (
    .phase (phase_p),
    .code  (lut_code)
  );

  always_comb begin
    q_d = DATA_W'(MIDSCALE);
    if (in_range) q_d = DATA_W'(lut_code);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) q_q <= DATA_W'(MIDSCALE);
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: tb/tb_left_rom_ip.sv
// Bench for left_rom_ip: cosine and sine instances share one address bus,
// expected codes queued at drive time and compared one edge later.
module tb_left_rom_ip;

  localparam real PI = 3.14159265358979;

  logic        clock;
  logic        rst_n;
  logic [11:0] address;
  logic [11:0] q_cos;
  logic [11:0] q_sin;

  int total = 0;
  int bad   = 0;
  int exp_c[$];
  int exp_s[$];

  left_rom_ip #(.ADDR_W(12), .DATA_W(12), .PHASE_OFS(25)) u_cos (
    .clock   (clock),
    .rst_n   (rst_n),
    .address (address),
    .q       (q_cos)
  );

  left_rom_ip #(.ADDR_W(12), .DATA_W(12), .PHASE_OFS(0)) u_sin (
    .clock   (clock),
    .rst_n   (rst_n),
    .address (address),
    .q       (q_sin)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int model_code(input int addr, input int ofs);
    int k, n, p;
    real v, r;
    if (addr >= 4000) return 2048;
    k = addr / 100;
    n = addr % 100;
    p = ((k + 1) * n + ofs) % 100;
    v = 2047.0 * $sin(2.0 * PI * real'(p) / 100.0);
    if (v >= 0.0) r = $floor(v + 0.5);
    else          r = -$floor(-v + 0.5);
    return 2048 + $rtoi(r);
  endfunction

  task automatic drive(input int a, input int ec, input int es);
    @(negedge clock);
    address = 12'(a);
    exp_c.push_back(ec);
    exp_s.push_back(es);
  endtask

  task automatic test_reset();
    int ec, es;
    rst_n   = 1'b0;
    address = 12'd0;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (q_cos !== 12'd2048) begin bad++; $display("FAIL reset_cos: got %0d want 2048", q_cos); end
    total++;
    if (q_sin !== 12'd2048) begin bad++; $display("FAIL reset_sin: got %0d want 2048", q_sin); end
    @(negedge clock);
    rst_n = 1'b1;
    #1;
    total++;
    if (q_cos !== 12'd2048) begin bad++; $display("FAIL reset_hold: got %0d want 2048", q_cos); end
    exp_c.push_back(4095);
    exp_s.push_back(2048);
    @(posedge clock);
    #1;
    ec = exp_c.pop_front();
    es = exp_s.pop_front();
    total++;
    if (q_cos !== 12'(ec)) begin bad++; $display("FAIL first_cos: got %0d want %0d", q_cos, ec); end
    total++;
    if (q_sin !== 12'(es)) begin bad++; $display("FAIL first_sin: got %0d want %0d", q_sin, es); end
  endtask

  task automatic test_cos_segment0();
    int addrs [4] = '{25, 50, 75, 99};
    int ecos  [4] = '{2048, 1, 2048, 4091};
    int esin  [4] = '{4095, 2048, 1, 1919};
    int prev_c = 4095;
    int ec, es;
    for (int i = 0; i < 4; i++) begin
      drive(addrs[i], ecos[i], esin[i]);
      #1;
      total++;
      if (q_cos !== 12'(prev_c)) begin
        bad++;
        $display("FAIL seg0_early a=%0d: got %0d want %0d", addrs[i], q_cos, prev_c);
      end
      @(posedge clock);
      #1;
      ec = exp_c.pop_front();
      es = exp_s.pop_front();
      total++;
      if (q_cos !== 12'(ec)) begin bad++; $display("FAIL seg0_cos a=%0d: got %0d want %0d", addrs[i], q_cos, ec); end
      total++;
      if (q_sin !== 12'(es)) begin bad++; $display("FAIL seg0_sin a=%0d: got %0d want %0d", addrs[i], q_sin, es); end
      prev_c = ec;
    end
  endtask

  task automatic test_segments();
    int addrs [3] = '{100, 150, 3999};
    int ecos  [3] = '{4095, 4095, 392};
    int esin  [3] = '{2048, 2048, 845};
    int ec, es;
    for (int i = 0; i < 3; i++) begin
      drive(addrs[i], ecos[i], esin[i]);
      @(posedge clock);
      #1;
      ec = exp_c.pop_front();
      es = exp_s.pop_front();
      total++;
      if (q_cos !== 12'(ec)) begin bad++; $display("FAIL seg_cos a=%0d: got %0d want %0d", addrs[i], q_cos, ec); end
      total++;
      if (q_sin !== 12'(es)) begin bad++; $display("FAIL seg_sin a=%0d: got %0d want %0d", addrs[i], q_sin, es); end
    end
  endtask

  task automatic test_out_of_range();
    int addrs [3] = '{4000, 4095, 0};
    int ecos  [3] = '{2048, 2048, 4095};
    int esin  [3] = '{2048, 2048, 2048};
    int ec, es;
    for (int i = 0; i < 3; i++) begin
      drive(addrs[i], ecos[i], esin[i]);
      @(posedge clock);
      #1;
      ec = exp_c.pop_front();
      es = exp_s.pop_front();
      total++;
      if (q_cos !== 12'(ec)) begin bad++; $display("FAIL oor_cos a=%0d: got %0d want %0d", addrs[i], q_cos, ec); end
      total++;
      if (q_sin !== 12'(es)) begin bad++; $display("FAIL oor_sin a=%0d: got %0d want %0d", addrs[i], q_sin, es); end
    end
  endtask

  task automatic test_sine();
    int addrs [3] = '{0, 25, 75};
    int ecos  [3] = '{4095, 2048, 2048};
    int esin  [3] = '{2048, 4095, 1};
    int ec, es;
    for (int i = 0; i < 3; i++) begin
      drive(addrs[i], ecos[i], esin[i]);
      @(posedge clock);
      #1;
      ec = exp_c.pop_front();
      es = exp_s.pop_front();
      total++;
      if (q_sin !== 12'(es)) begin bad++; $display("FAIL sine_sin a=%0d: got %0d want %0d", addrs[i], q_sin, es); end
      total++;
      if (q_cos !== 12'(ec)) begin bad++; $display("FAIL sine_cos a=%0d: got %0d want %0d", addrs[i], q_cos, ec); end
    end
  endtask

  task automatic test_back_to_back();
    int ec, es;
    for (int a = 0; a < 4096; a++) begin
      drive(a, model_code(a, 25), model_code(a, 0));
      @(posedge clock);
      #1;
      ec = exp_c.pop_front();
      es = exp_s.pop_front();
      total++;
      if (q_cos !== 12'(ec)) begin bad++; $display("FAIL sweep_cos a=%0d: got %0d want %0d", a, q_cos, ec); end
      total++;
      if (q_sin !== 12'(es)) begin bad++; $display("FAIL sweep_sin a=%0d: got %0d want %0d", a, q_sin, es); end
    end
  endtask

  task automatic test_wrap();
    int ec, es;
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 100; n++) begin
        drive(1700 + n, model_code(1700 + n, 25), model_code(1700 + n, 0));
        @(posedge clock);
        #1;
        ec = exp_c.pop_front();
        es = exp_s.pop_front();
        total++;
        if (q_cos !== 12'(ec)) begin bad++; $display("FAIL wrap_cos n=%0d: got %0d want %0d", n, q_cos, ec); end
        total++;
        if (q_sin !== 12'(es)) begin bad++; $display("FAIL wrap_sin n=%0d: got %0d want %0d", n, q_sin, es); end
      end
    end
  endtask

  task automatic test_async_reset();
    int ec, es;
    drive(123, model_code(123, 25), model_code(123, 0));
    @(posedge clock);
    #1;
    ec = exp_c.pop_front();
    es = exp_s.pop_front();
    total++;
    if (q_cos !== 12'(ec)) begin bad++; $display("FAIL pre_rst_cos: got %0d want %0d", q_cos, ec); end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (q_cos !== 12'd2048) begin bad++; $display("FAIL async_rst_cos: got %0d want 2048", q_cos); end
    total++;
    if (q_sin !== 12'd2048) begin bad++; $display("FAIL async_rst_sin: got %0d want 2048", q_sin); end
    @(negedge clock);
    address = 12'd456;
    @(posedge clock);
    #1;
    total++;
    if (q_cos !== 12'd2048) begin bad++; $display("FAIL rst_held_cos: got %0d want 2048", q_cos); end
    @(negedge clock);
    rst_n = 1'b1;
    exp_c.push_back(model_code(456, 25));
    exp_s.push_back(model_code(456, 0));
    @(posedge clock);
    #1;
    ec = exp_c.pop_front();
    es = exp_s.pop_front();
    total++;
    if (q_cos !== 12'(ec)) begin bad++; $display("FAIL post_rst_cos: got %0d want %0d", q_cos, ec); end
    total++;
    if (q_sin !== 12'(es)) begin bad++; $display("FAIL post_rst_sin: got %0d want %0d", q_sin, es); end
  endtask

  initial begin
    rst_n   = 1'b0;
    address = 12'd0;
    test_reset();
    test_cos_segment0();
    test_segments();
    test_out_of_range();
    test_sine();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
